scan_mux: RTL and testbench

//   Parametrised, registered N-channel x WIDTH-bit multiplexer; successor to the 32:1 single-bit mux.
//   Two modes: manual (channel taken from select) and auto-scan (internal counter walks channels 0..N-1).

---
 rtl/scan_mux.sv | 108 ++++++++++
 tb/tb_scan_mux.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/scan_mux.sv
// Registered N-channel x WIDTH-bit mux with manual select or auto-scan, valid/ready output.
// Latency 1 cycle; a stalled sample (valid & ~ready) holds output and freezes scan state.
module scan_mux #(
  parameter int N_INPUTS = 32,
  parameter int WIDTH    = 8,
  parameter int DWELL    = 1,
  parameter int SEL_W    = $clog2(N_INPUTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          select,
  input  logic [N_INPUTS*WIDTH-1:0] inputs,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err
);

  localparam int                DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W:0]    N_EXT      = (SEL_W+1)'(N_INPUTS);
  localparam logic [SEL_W-1:0]  LAST_IDX   = SEL_W'(N_INPUTS - 1);
  localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL - 1);

  typedef enum logic {IDLE, FULL} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] out_q;
  logic [SEL_W-1:0] out_sel_q;
  logic             sel_err_q;
  logic [SEL_W-1:0] scan_idx_q, scan_idx_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic             prev_mode_q;

  logic             load;
  logic             mode_chg;
  logic [SEL_W-1:0] scan_base;
  logic [DW_W-1:0]  dwell_base;
  logic [SEL_W-1:0] chan;
  logic             sel_oor;
  logic [WIDTH-1:0] chan_dat;

  assign out_valid = (state_q == FULL);
  assign out       = out_q;
  assign out_sel   = out_sel_q;
  assign sel_err   = sel_err_q;

  assign load = ena & (~out_valid | out_ready);

  // Entering scan from manual restarts the walk at channel 0 before this load uses it.
  assign mode_chg   = (mode != prev_mode_q);
  assign scan_base  = mode_chg ? '0 : scan_idx_q;
  assign dwell_base = mode_chg ? '0 : dwell_q;

  assign chan    = mode ? scan_base : select;
  assign sel_oor = ~mode & ({1'b0, select} >= N_EXT);

  always_comb begin
    chan_dat = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      if (chan == SEL_W'(k)) chan_dat = inputs[k*WIDTH +: WIDTH];
    end
    if (sel_oor) chan_dat = '0;
  end

  always_comb begin
    scan_idx_d = scan_base;
    dwell_d    = dwell_base;
    if (dwell_base == DWELL_LAST) begin
      dwell_d    = '0;
      scan_idx_d = (scan_base == LAST_IDX) ? '0 : scan_base + SEL_W'(1);
    end else begin
      dwell_d    = dwell_base + DW_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_q       <= '0;
      out_sel_q   <= '0;
      sel_err_q   <= 1'b0;
      scan_idx_q  <= '0;
      dwell_q     <= '0;
      prev_mode_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (load) state_q <= FULL;
        FULL: if (!load && out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (load) begin
        out_q       <= chan_dat;
        out_sel_q   <= chan;
        sel_err_q   <= sel_oor;
        prev_mode_q <= mode;
        // Scan position only moves on scan-mode loads; manual loads leave it frozen.
        if (mode) begin
          scan_idx_q <= scan_idx_d;
          dwell_q    <= dwell_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: three instances cover 32-ch manual, 5-ch scan/select/reset,
// and 4-ch scan with DWELL=3 under backpressure.
module tb_scan_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance A: 32 channels, DWELL=1
  logic         a_ena = 1'b0, a_mode = 1'b0, a_ready = 1'b0;
  logic [4:0]   a_select = '0;
  logic [255:0] a_inputs;
  logic [7:0]   a_out;
  logic [4:0]   a_out_sel;
  logic         a_valid, a_err;

  scan_mux #(.N_INPUTS(32), .WIDTH(8), .DWELL(1)) u_a (
    .clk(clk), .rst(rst), .ena(a_ena), .mode(a_mode), .select(a_select),
    .inputs(a_inputs), .out(a_out), .out_sel(a_out_sel), .out_valid(a_valid),
    .out_ready(a_ready), .sel_err(a_err)
  );

  // Instance B: 5 channels, DWELL=1
  logic         b_ena = 1'b0, b_mode = 1'b0, b_ready = 1'b0;
  logic [2:0]   b_select = '0;
  logic [39:0]  b_inputs;
  logic [7:0]   b_out;
  logic [2:0]   b_out_sel;
  logic         b_valid, b_err;

  scan_mux #(.N_INPUTS(5), .WIDTH(8), .DWELL(1)) u_b (
    .clk(clk), .rst(rst), .ena(b_ena), .mode(b_mode), .select(b_select),
    .inputs(b_inputs), .out(b_out), .out_sel(b_out_sel), .out_valid(b_valid),
    .out_ready(b_ready), .sel_err(b_err)
  );

  // Instance C: 4 channels, DWELL=3
  logic         c_ena = 1'b0, c_mode = 1'b0, c_ready = 1'b0;
  logic [1:0]   c_select = '0;
  logic [31:0]  c_inputs;
  logic [7:0]   c_out;
  logic [1:0]   c_out_sel;
  logic         c_valid, c_err;

  scan_mux #(.N_INPUTS(4), .WIDTH(8), .DWELL(3)) u_c (
    .clk(clk), .rst(rst), .ena(c_ena), .mode(c_mode), .select(c_select),
    .inputs(c_inputs), .out(c_out), .out_sel(c_out_sel), .out_valid(c_valid),
    .out_ready(c_ready), .sel_err(c_err)
  );

  initial begin
    for (int k = 0; k < 32; k++) a_inputs[k*8 +: 8] = 8'(k) ^ 8'hA5;
    for (int k = 0; k < 5; k++)  b_inputs[k*8 +: 8] = 8'h30 + 8'(k);
    for (int k = 0; k < 4; k++)  c_inputs[k*8 +: 8] = 8'hC0 + 8'(k);
  end

  initial begin
    int n;
    int exp_sel;

    // Reset state
    #12;
    check_eq("rst_a_valid", 32'(a_valid), 32'd0);
    check_eq("rst_a_out",   32'(a_out),   32'd0);
    check_eq("rst_b_sel",   32'(b_out_sel), 32'd0);
    check_eq("rst_b_err",   32'(b_err),   32'd0);
    check_eq("rst_c_valid", 32'(c_valid), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("idle_a_valid", 32'(a_valid), 32'd0);

    // 1: manual sweep of all 32 channels
    a_ena = 1'b1; a_ready = 1'b1; a_mode = 1'b0;
    for (int k = 0; k < 32; k++) begin
      a_select = 5'(k);
      tick();
      check_eq("t1_out",   32'(a_out),     32'(8'(k) ^ 8'hA5));
      check_eq("t1_sel",   32'(a_out_sel), 32'(k));
      check_eq("t1_err",   32'(a_err),     32'd0);
      check_eq("t1_valid", 32'(a_valid),   32'd1);
    end
    a_ena = 1'b0;

    // 3: DWELL=3 scan with a 4-cycle stall mid-dwell
    c_ena = 1'b1; c_mode = 1'b1;
    n = 0; exp_sel = 0;
    for (int i = 0; i < 20; i++) begin
      c_ready = !(i >= 5 && i < 9);
      tick();
      if (c_ready) begin
        exp_sel = (n / 3) % 4;
        n++;
      end
      check_eq("t3_sel",   32'(c_out_sel), 32'(exp_sel));
      check_eq("t3_out",   32'(c_out),     32'(8'hC0 + 8'(exp_sel)));
      check_eq("t3_valid", 32'(c_valid),   32'd1);
    end
    c_ena = 1'b0;

    // 2: 5-channel scan wraps 4 -> 0
    b_ena = 1'b1; b_ready = 1'b1; b_mode = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq("t2_sel", 32'(b_out_sel), 32'(i % 5));
      check_eq("t2_out", 32'(b_out),     32'(8'h30 + 8'(i % 5)));
      check_eq("t2_err", 32'(b_err),     32'd0);
    end

    // 4: out-of-range manual select, then in-range
    b_mode = 1'b0; b_select = 3'd6;
    tick();
    check_eq("t4_oor_out", 32'(b_out),     32'd0);
    check_eq("t4_oor_sel", 32'(b_out_sel), 32'd6);
    check_eq("t4_oor_err", 32'(b_err),     32'd1);
    b_select = 3'd2;
    tick();
    check_eq("t4_ok_err", 32'(b_err),     32'd0);
    check_eq("t4_ok_out", 32'(b_out),     32'h32);
    check_eq("t4_ok_sel", 32'(b_out_sel), 32'd2);

    // 6: scan to channel 2, manual select=7 twice, back to scan restarts at 0
    b_mode = 1'b1;
    tick(); tick(); tick();
    check_eq("t6_scan2", 32'(b_out_sel), 32'd2);
    b_mode = 1'b0; b_select = 3'd7;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("t6_man_sel", 32'(b_out_sel), 32'd7);
      check_eq("t6_man_err", 32'(b_err),     32'd1);
    end
    b_mode = 1'b1;
    tick();
    check_eq("t6_restart0", 32'(b_out_sel), 32'd0);
    check_eq("t6_restart_err", 32'(b_err),  32'd0);
    tick();
    check_eq("t6_next1", 32'(b_out_sel), 32'd1);
    b_ena = 1'b0; b_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t6_hold_valid", 32'(b_valid),   32'd1);
      check_eq("t6_hold_sel",   32'(b_out_sel), 32'd1);
      check_eq("t6_hold_out",   32'(b_out),     32'h31);
    end
    b_ready = 1'b1;
    tick();
    check_eq("t6_drain_valid", 32'(b_valid), 32'd0);
    b_ena = 1'b1;
    tick();
    check_eq("t6_resume2", 32'(b_out_sel), 32'd2);
    tick();
    check_eq("t6_at3", 32'(b_out_sel), 32'd3);

    // 5: async reset between edges
    #3;
    rst = 1'b1;
    #1;
    check_eq("t5_valid", 32'(b_valid),   32'd0);
    check_eq("t5_out",   32'(b_out),     32'd0);
    check_eq("t5_sel",   32'(b_out_sel), 32'd0);
    check_eq("t5_a_out", 32'(a_out),     32'd0);
    #1;
    rst = 1'b0;
    tick();
    check_eq("t5_first_sel",   32'(b_out_sel), 32'd0);
    check_eq("t5_first_out",   32'(b_out),     32'h30);
    check_eq("t5_first_valid", 32'(b_valid),   32'd1);
    tick();
    check_eq("t5_second_sel", 32'(b_out_sel), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
